// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the memory-mapped UART write port through a 3-state drain engine.
// Optional feature macro UART_TXQ_CRLF_EN: emit 8'h0D ahead of every queued 8'h0A.
module uart_tx_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              uart_we,
  output logic [7:0]        uart_wdata,
  input  logic              uart_ready
);

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overflow;
  logic              r_uart_we;
  logic [7:0]        r_uart_wdata;
  state_t            r_state;
  state_t            w_state_next;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drop;
  logic              w_latch;
  logic              w_pop;
  logic              w_insert_cr;
  logic [7:0]        w_head;
  logic [7:0]        w_latch_data;

  assign w_full     = (r_level == LP_FULL);
  assign w_empty    = (r_level == '0);
  assign w_head     = r_mem[r_rd_ptr];
  // Full is judged on the pre-edge level, so a same-cycle pop never rescues a push.
  assign w_push     = wr_en && !w_full;
  assign w_drop     = wr_en && w_full;

  assign full       = w_full;
  assign empty      = w_empty;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign uart_we    = r_uart_we;
  assign uart_wdata = r_uart_wdata;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef UART_TXQ_CRLF_EN
  logic r_cr_done;

  assign w_insert_cr = (w_head == 8'h0A) && !r_cr_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cr_done <= 1'b0;
    end else if (w_latch) begin
      r_cr_done <= w_insert_cr;
    end
  end
`else
  assign w_insert_cr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // SETTLE deliberately ignores uart_ready: the UART lags one cycle after a write.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty && uart_ready) w_state_next = S_ISSUE;
      S_ISSUE:  w_state_next = S_SETTLE;
      S_SETTLE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch      = 1'b0;
    w_pop        = 1'b0;
    w_latch_data = w_head;
    if (r_state == S_IDLE && !w_empty && uart_ready) begin
      w_latch      = 1'b1;
      w_pop        = !w_insert_cr;
      w_latch_data = w_insert_cr ? 8'h0D : w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_uart_we    <= 1'b0;
      r_uart_wdata <= 8'h00;
    end else begin
      r_uart_we <= (w_state_next == S_ISSUE);
      if (w_latch) begin
        r_uart_wdata <= w_latch_data;
      end
    end
  end

endmodule
